// File: rtl/digipot_ctrl.sv
// digipot_ctrl: SPI mode-0 write controller for up to three digital potentiometers.
// The pots share one SDI/SCLK bus and each has its own active-low chip select.
// A rising edge on ctrl latches dato and mux, then shifts the frame out MSB first.
// Optional build macro DIGIPOT_CMD_EN adds the command byte 0x11 ahead of dato,
// which gives a 16-bit frame. The default build sends the 8-bit dato frame alone.
module digipot_ctrl #(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mux,
    input  logic              ctrl,
    input  logic [DATA_W-1:0] dato,
    output logic              cs1,
    output logic              cs2,
    output logic              cs3,
    output logic              sdi,
    output logic              clk_out,
    output logic              busy
);

`ifdef DIGIPOT_CMD_EN
    localparam int unsigned FRAME_W = DATA_W + 8;
`else
    localparam int unsigned FRAME_W = DATA_W;
`endif
    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(FRAME_W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic [FRAME_W-1:0] shreg, sh_n;
    logic [2:0]         cs_q, cs_n;
    logic               sdi_n, clk_n, busy_n;
    logic               ctrl_q;
    logic               start;
    logic               cnt_done;
    logic [FRAME_W-1:0] load;
    logic [2:0]         cs_sel;

    assign start    = ctrl & ~ctrl_q;
    assign cnt_done = (cnt == CNT_W'(CLK_DIV - 1));
`ifdef DIGIPOT_CMD_EN
    assign load = {8'h11, dato};
`else
    assign load = dato;
`endif

    // Decode the target select into the active-low chip-select pattern; 3 broadcasts to all pots
    always_comb begin
        cs_sel = 3'b111;
        case (mux)
            2'd0:    cs_sel = 3'b110;
            2'd1:    cs_sel = 3'b101;
            2'd2:    cs_sel = 3'b011;
            default: cs_sel = 3'b000;
        endcase
    end

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        cs_n    = cs_q;
        sdi_n   = sdi;
        clk_n   = clk_out;
        busy_n  = busy;
        case (state)
            IDLE: begin
                cs_n   = 3'b111;
                sdi_n  = 1'b0;
                clk_n  = 1'b0;
                busy_n = 1'b0;
                cnt_n  = '0;
                if (start) begin
                    sh_n    = load;
                    sdi_n   = load[FRAME_W-1];
                    busy_n  = 1'b1;
                    cs_n    = cs_sel;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    cnt_n   = '0;
                    clk_n   = 1'b1;
                    bit_n   = '0;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (!cnt_done) begin
                    cnt_n = cnt + CNT_W'(1);
                end else begin
                    cnt_n = '0;
                    if (clk_out) begin
                        // The falling edge of clk_out moves sdi to the next bit
                        clk_n = 1'b0;
                        sh_n  = {shreg[FRAME_W-2:0], 1'b0};
                        sdi_n = shreg[FRAME_W-2];
                    end else if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                        state_n = HOLD;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                        clk_n = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!cnt_done) begin
                    cnt_n = cnt + CNT_W'(1);
                end else begin
                    cnt_n   = '0;
                    cs_n    = 3'b111;
                    sdi_n   = 1'b0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset forces every pin to its idle level at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            cs_q    <= 3'b111;
            sdi     <= 1'b0;
            clk_out <= 1'b0;
            busy    <= 1'b0;
            ctrl_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
            cs_q    <= cs_n;
            sdi     <= sdi_n;
            clk_out <= clk_n;
            busy    <= busy_n;
            ctrl_q  <= ctrl;
        end
    end

    assign cs1 = cs_q[0];
    assign cs2 = cs_q[1];
    assign cs3 = cs_q[2];

endmodule

// File: tb/tb_digipot_ctrl.sv
// Testbench for digipot_ctrl: table-driven and random frames checked against a frame-level model.
module tb_digipot_ctrl;

    localparam int unsigned CLK_DIV = 1;
    localparam int unsigned DATA_W  = 8;
`ifdef DIGIPOT_CMD_EN
    localparam int unsigned FW = DATA_W + 8;
`else
    localparam int unsigned FW = DATA_W;
`endif
    localparam int unsigned LOW_CYC = 2 * CLK_DIV + 2 * FW * CLK_DIV;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mux;
    logic              ctrl;
    logic [DATA_W-1:0] dato;
    logic              cs1, cs2, cs3, sdi, clk_out, busy;

    int total = 0;
    int bad   = 0;

    digipot_ctrl #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .mux(mux), .ctrl(ctrl), .dato(dato),
        .cs1(cs1), .cs2(cs2), .cs3(cs3), .sdi(sdi), .clk_out(clk_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        mux;
        logic [DATA_W-1:0] dato;
        logic [2:0]        exp_cs;   // {cs3,cs2,cs1} while the frame is active
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Chip-select pattern the pots should see for a given target select
    function automatic logic [2:0] model_cs(input logic [1:0] m);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = !((m == 2'd3) || (m == 2'(i)));
        return r;
    endfunction

    function automatic logic [FW-1:0] model_frame(input logic [DATA_W-1:0] d);
`ifdef DIGIPOT_CMD_EN
        return {8'h11, d};
`else
        return d;
`endif
    endfunction

    task automatic pulse(input int len);
        ctrl = 1'b1;
        repeat (len) @(posedge clk);
        #1 ctrl = 1'b0;
    endtask

    // Watch one frame from CS fall to CS rise and compare it with the model
    task automatic observe(input logic [2:0] exp_cs, input logic [FW-1:0] exp_d, input string nm);
        int waitc = 0;
        int low = 0;
        int rises = 0;
        int first = -1;
        logic [FW-1:0] cap = '0;
        logic prev = 1'b0;
        bit csbad = 0;
        bit busybad = 0;
        @(negedge clk);
        while ({cs3, cs2, cs1} == 3'b111 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        check({nm, "_started"}, 32'(waitc < 10), 32'd1);
        if (waitc >= 10) return;
        while ({cs3, cs2, cs1} != 3'b111 && low < 200) begin
            if ({cs3, cs2, cs1} != exp_cs) csbad = 1;
            if (!busy) busybad = 1;
            if (clk_out && !prev) begin
                if (first < 0) first = low;
                cap = {cap[FW-2:0], sdi};
                rises++;
            end
            prev = clk_out;
            low++;
            @(negedge clk);
        end
        check({nm, "_cs_pattern"}, 32'(csbad), 32'd0);
        check({nm, "_busy_during"}, 32'(busybad), 32'd0);
        check({nm, "_cs_low_cycles"}, 32'(low), 32'(LOW_CYC));
        check({nm, "_pulses"}, 32'(rises), 32'(FW));
        check({nm, "_first_rise"}, 32'(first), 32'(CLK_DIV));
        check({nm, "_data"}, 32'(cap), 32'(exp_d));
        check({nm, "_idle_after"}, {29'd0, busy, clk_out, sdi}, 32'd0);
    endtask

    // Confirm nothing starts for n cycles
    task automatic quiet(input int n, input string nm);
        bit act = 0;
        repeat (n) begin
            @(negedge clk);
            if ({cs3, cs2, cs1} != 3'b111 || clk_out || busy) act = 1;
        end
        check(nm, 32'(act), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{mux: 2'd0, dato: 8'hAA, exp_cs: 3'b110};
        vecs[1] = '{mux: 2'd1, dato: 8'h5A, exp_cs: 3'b101};
        vecs[2] = '{mux: 2'd2, dato: 8'h5A, exp_cs: 3'b011};
        vecs[3] = '{mux: 2'd3, dato: 8'h5A, exp_cs: 3'b000};

        rst = 1'b1; ctrl = 1'b0; mux = 2'd0; dato = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {26'd0, cs3, cs2, cs1, sdi, clk_out, busy}, 32'h38);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table, ctrl held for one or two cycles
        for (int i = 0; i < 4; i++) begin
            mux = vecs[i].mux; dato = vecs[i].dato;
            fork
                pulse(1 + (i % 2));
                observe(vecs[i].exp_cs, model_frame(vecs[i].dato), $sformatf("vec%0d", i));
            join
            @(posedge clk); #1;
        end

        // ctrl edge five cycles into a frame with new dato is ignored
        mux = 2'd0; dato = 8'hAA;
        fork
            pulse(1);
            observe(3'b110, model_frame(8'hAA), "busy_ign");
            begin
                repeat (5) @(posedge clk);
                #1 dato = 8'h00; mux = 2'd3;
                pulse(1);
            end
        join
        quiet(40, "busy_ign_no_second");
        @(posedge clk); #1;

        // A level held high starts only one frame
        mux = 2'd1; dato = 8'h3C;
        fork
            pulse(60);
            observe(3'b101, model_frame(8'h3C), "held");
        join
        quiet(50, "held_no_retrigger");
        @(posedge clk); #1;

        // Back-to-back frames every 43 cycles with mux stepping
        for (int i = 0; i < 4; i++) begin
            mux = 2'(i); dato = 8'(8'h81 + i);
            fork
                begin
                    pulse(1);
                    repeat (42) @(posedge clk);
                    #1;
                end
                observe(model_cs(2'(i)), model_frame(8'(8'h81 + i)), $sformatf("b2b%0d", i));
            join
        end

        // Randomised frames
        for (int i = 0; i < 12; i++) begin
            logic [1:0] m;
            logic [DATA_W-1:0] d;
            m = 2'($urandom_range(0, 3));
            d = DATA_W'($urandom);
            mux = m; dato = d;
            fork
                pulse(int'($urandom_range(1, 2)));
                observe(model_cs(m), model_frame(d), $sformatf("rnd%0d", i));
            join
            @(posedge clk); #1;
        end

        // Reset in mid-frame clears the pins without waiting for a clock edge
        mux = 2'd3; dato = 8'hFF;
        pulse(1);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_async", {26'd0, cs3, cs2, cs1, sdi, clk_out, busy}, 32'h38);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        quiet(40, "rst_no_pulses");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
